// File: rtl/output_deformatter.sv
// Receive-side decoder for the 3x64-bit EMTF->uGMT track words: unpacks track fields, recovers BC0/BX,
// tracks BX alignment against a local counter, and keeps error counters and per-slot valid-track rates.
module output_deformatter #(
    parameter int ORBIT_LEN   = 3564,
    parameter int ERR_LIMIT   = 4,
    parameter int RATE_PERIOD = 40078700
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0][63:0] rxdata,
    output logic [2:0]       trk_vld,
    output logic [2:0][8:0]  trk_pt,
    output logic [2:0][3:0]  trk_qlt,
    output logic [2:0][8:0]  trk_eta,
    output logic [2:0][7:0]  trk_phi,
    output logic [2:0]       trk_crg,
    output logic [2:0]       trk_cvl,
    output logic [2:0][15:0] trk_id,
    output logic             bc0_out,
    output logic             locked,
    output logic [15:0]      bx_err_cnt,
    output logic [15:0]      idx_err_cnt,
    output logic [15:0]      bc0_err_cnt,
    output logic [2:0][25:0] track_rate
);
    localparam int PW = $clog2(RATE_PERIOD + 1);
    localparam int RW = $clog2(ERR_LIMIT + 1);
    localparam logic [11:0] LAST_BX = 12'(ORBIT_LEN - 1);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    typedef struct packed {
        logic [15:0] id;
        logic        cvl;
        logic        crg;
        logic [7:0]  phi;
        logic [8:0]  eta;
        logic [3:0]  qlt;
        logic [8:0]  pt;
    } trk_t;

    state_t            state_q, state_d;
    logic [11:0]       bxn_q, bxn_d;
    logic [RW-1:0]     run_q, run_d;
    logic [15:0]       bx_err_q, bx_err_d, idx_err_q, idx_err_d, bc0_err_q, bc0_err_d;
    logic [PW-1:0]     period_q, period_d;
    logic [2:0][25:0]  cnt_q, cnt_d, rate_q, rate_d;
    trk_t [2:0]        trk_q, trk_d;
    logic [2:0]        vld_q;
    logic              bc0_q;

    logic              bc0;
    logic [2:0]        rx_bxn3;
    logic [2:0]        slot_vld, idx_bad;
    logic [1:0]        n_idx_bad;
    logic              unused_bits;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, inc};
        return s[16] ? 16'hffff : s[15:0];
    endfunction

    function automatic logic [25:0] sat_inc26(input logic [25:0] a, input logic inc);
        return (inc && (a != 26'h3ffffff)) ? a + 26'd1 : a;
    endfunction

    assign bc0         = rxdata[0][31];
    assign rx_bxn3     = {rxdata[2][31], rxdata[1][63], rxdata[1][31]};
    assign unused_bits = ^{rxdata[0][63], rxdata[2][63], rxdata[0][22], rxdata[1][22], rxdata[2][22]};

    // Per-slot decode: validity, index/embedded-bxn check, masked field capture
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            slot_vld[i] = (rxdata[i][8:0] != 9'd0) || (rxdata[i][12:9] != 4'd0);
            idx_bad[i]  = slot_vld[i] && ((rxdata[i][51:50] != 2'(i)) ||
                                          (rxdata[i][62:52] != bxn_q[10:0]));
            trk_d[i]    = slot_vld[i] ? trk_t'({rxdata[i][49:32], rxdata[i][30:23], rxdata[i][21:0]})
                                      : trk_t'('0);
        end
        n_idx_bad = {1'b0, idx_bad[0]} + {1'b0, idx_bad[1]} + {1'b0, idx_bad[2]};
    end

    // Alignment FSM, error counters and rate window next-state
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        bx_err_d  = bx_err_q;
        idx_err_d = idx_err_q;
        bc0_err_d = bc0_err_q;
        bxn_d     = bc0 ? 12'd0 : bxn_q + 12'd1;

        case (state_q)
            UNLOCKED: begin
                if (bc0) begin
                    state_d = LOCKED;
                    run_d   = '0;
                end
            end
            LOCKED: begin
                if (bc0) begin
                    run_d = '0;
                    if (bxn_q != LAST_BX) bc0_err_d = sat_add16(bc0_err_q, 2'd1);
                end else if (bxn_q == LAST_BX) begin
                    bc0_err_d = sat_add16(bc0_err_q, 2'd1);
                    state_d   = UNLOCKED;
                    run_d     = '0;
                end else begin
                    if (rx_bxn3 != bxn_q[2:0]) begin
                        bx_err_d = sat_add16(bx_err_q, 2'd1);
                        if (run_q == RW'(ERR_LIMIT - 1)) begin
                            state_d = UNLOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RW'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                    idx_err_d = sat_add16(idx_err_q, n_idx_bad);
                end
            end
            default: state_d = UNLOCKED;
        endcase

        rate_d = rate_q;
        cnt_d  = cnt_q;
        if (period_q == PW'(RATE_PERIOD)) begin
            rate_d   = cnt_q;
            cnt_d    = '0;
            period_d = '0;
        end else begin
            period_d = period_q + PW'(1);
            for (int i = 0; i < 3; i++) cnt_d[i] = sat_inc26(cnt_q[i], slot_vld[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= UNLOCKED;
            bxn_q     <= '0;
            run_q     <= '0;
            bx_err_q  <= '0;
            idx_err_q <= '0;
            bc0_err_q <= '0;
            period_q  <= '0;
            cnt_q     <= '0;
            rate_q    <= '0;
            trk_q     <= '0;
            vld_q     <= '0;
            bc0_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bxn_q     <= bxn_d;
            run_q     <= run_d;
            bx_err_q  <= bx_err_d;
            idx_err_q <= idx_err_d;
            bc0_err_q <= bc0_err_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            rate_q    <= rate_d;
            trk_q     <= trk_d;
            vld_q     <= slot_vld;
            bc0_q     <= bc0;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            trk_pt[i]  = trk_q[i].pt;
            trk_qlt[i] = trk_q[i].qlt;
            trk_eta[i] = trk_q[i].eta;
            trk_phi[i] = trk_q[i].phi;
            trk_crg[i] = trk_q[i].crg;
            trk_cvl[i] = trk_q[i].cvl;
            trk_id[i]  = trk_q[i].id;
        end
    end

    assign trk_vld     = vld_q;
    assign bc0_out     = bc0_q;
    assign locked      = (state_q == LOCKED);
    assign bx_err_cnt  = bx_err_q;
    assign idx_err_cnt = idx_err_q;
    assign bc0_err_cnt = bc0_err_q;
    assign track_rate  = rate_q;
endmodule

// File: tb/tb_output_deformatter.sv
// Directed self-checking bench for output_deformatter (rate window shortened to 100 clocks).
module tb_output_deformatter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [2:0][63:0] rxdata;
    logic [2:0]       trk_vld;
    logic [2:0][8:0]  trk_pt;
    logic [2:0][3:0]  trk_qlt;
    logic [2:0][8:0]  trk_eta;
    logic [2:0][7:0]  trk_phi;
    logic [2:0]       trk_crg;
    logic [2:0]       trk_cvl;
    logic [2:0][15:0] trk_id;
    logic             bc0_out;
    logic             locked;
    logic [15:0]      bx_err_cnt, idx_err_cnt, bc0_err_cnt;
    logic [2:0][25:0] track_rate;

    int checks = 0;
    int errors = 0;
    logic [11:0] lb = 12'd0;   // expected local bxn

    output_deformatter #(.ORBIT_LEN(3564), .ERR_LIMIT(4), .RATE_PERIOD(100)) dut (
        .clk(clk), .rst_n(rst_n), .rxdata(rxdata),
        .trk_vld(trk_vld), .trk_pt(trk_pt), .trk_qlt(trk_qlt), .trk_eta(trk_eta),
        .trk_phi(trk_phi), .trk_crg(trk_crg), .trk_cvl(trk_cvl), .trk_id(trk_id),
        .bc0_out(bc0_out), .locked(locked), .bx_err_cnt(bx_err_cnt),
        .idx_err_cnt(idx_err_cnt), .bc0_err_cnt(bc0_err_cnt), .track_rate(track_rate)
    );

    task automatic tick();
        @(posedge clk);
        if (!rst_n || rxdata[0][31]) lb = 12'd0;
        else lb = lb + 12'd1;
        #1;
    endtask

    task automatic set_frame(input logic [2:0] bx3, input logic bc0);
        rxdata = '0;
        rxdata[0][31] = bc0;
        rxdata[1][31] = bx3[0];
        rxdata[1][63] = bx3[1];
        rxdata[2][31] = bx3[2];
    endtask

    task automatic drive_good(input int n);
        repeat (n) begin
            set_frame(lb[2:0], 1'b0);
            tick();
        end
    endtask

    function automatic logic [63:0] mk_trk(input logic [8:0] pt, input logic [3:0] qlt, input logic [8:0] eta,
                                           input logic [7:0] phi, input logic crg, input logic cvl,
                                           input logic [15:0] id, input logic [1:0] idx, input logic [10:0] bxf);
        logic [63:0] w;
        w = '0;
        w[8:0] = pt; w[12:9] = qlt; w[21:13] = eta; w[30:23] = phi;
        w[32] = crg; w[33] = cvl; w[49:34] = id; w[51:50] = idx; w[62:52] = bxf;
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        rxdata = '0;
        repeat (3) tick();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
        checks++; if (trk_vld !== 3'b000) begin errors++; $display("FAIL reset_vld: got %b want 000", trk_vld); end
        checks++; if (bx_err_cnt !== 16'd0 || idx_err_cnt !== 16'd0 || bc0_err_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_errcnt: got %0h/%0h/%0h want 0/0/0", bx_err_cnt, idx_err_cnt, bc0_err_cnt); end
        checks++; if (track_rate !== '0 || bc0_out !== 1'b0 || trk_pt !== '0 || trk_id !== '0) begin
            errors++; $display("FAIL reset_outputs: rate %0h bc0 %0b pt %0h id %0h want 0", track_rate, bc0_out, trk_pt, trk_id); end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (trk_vld !== 3'b000 || locked !== 1'b0) begin
                errors++; $display("FAIL idle_%0d: vld %b locked %0b want 000/0", k, trk_vld, locked); end
        end
    endtask

    task automatic test_lock();
        set_frame(3'd0, 1'b1);
        tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_on_bc0: got %0b want 1", locked); end
        checks++; if (bc0_out !== 1'b1) begin errors++; $display("FAIL bc0_out_hi: got %0b want 1", bc0_out); end
        drive_good(3563);
        checks++; if (locked !== 1'b1 || bc0_out !== 1'b0) begin
            errors++; $display("FAIL orbit_run: locked %0b bc0_out %0b want 1/0", locked, bc0_out); end
        set_frame(3'd0, 1'b1);
        tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL orbit_bc0_locked: got %0b want 1", locked); end
        checks++; if (bx_err_cnt !== 16'd0 || idx_err_cnt !== 16'd0 || bc0_err_cnt !== 16'd0) begin
            errors++; $display("FAIL orbit_errcnt: got %0d/%0d/%0d want 0/0/0", bx_err_cnt, idx_err_cnt, bc0_err_cnt); end
    endtask

    task automatic test_bx_err();
        repeat (3) begin set_frame(lb[2:0] ^ 3'b101, 1'b0); tick(); end
        checks++; if (bx_err_cnt !== 16'd3 || locked !== 1'b1) begin
            errors++; $display("FAIL bx_err_3: cnt %0d locked %0b want 3/1", bx_err_cnt, locked); end
        set_frame(lb[2:0] ^ 3'b101, 1'b0); tick();
        checks++; if (bx_err_cnt !== 16'd4 || locked !== 1'b0) begin
            errors++; $display("FAIL bx_err_4: cnt %0d locked %0b want 4/0", bx_err_cnt, locked); end
        set_frame(3'd0, 1'b1); tick();
        checks++; if (locked !== 1'b1 || bc0_err_cnt !== 16'd0) begin
            errors++; $display("FAIL relock: locked %0b bc0_err %0d want 1/0", locked, bc0_err_cnt); end
        repeat (3) begin set_frame(lb[2:0] ^ 3'b010, 1'b0); tick(); end
        drive_good(1);
        checks++; if (bx_err_cnt !== 16'd7 || locked !== 1'b1) begin
            errors++; $display("FAIL bx_3_then_good: cnt %0d locked %0b want 7/1", bx_err_cnt, locked); end
        repeat (3) begin set_frame(lb[2:0] ^ 3'b001, 1'b0); tick(); end
        set_frame(lb[2:0], 1'b1); tick();
        checks++; if (locked !== 1'b1 || bc0_err_cnt !== 16'd1 || bx_err_cnt !== 16'd10) begin
            errors++; $display("FAIL bc0_beats_run: locked %0b bc0_err %0d bx_err %0d want 1/1/10",
                               locked, bc0_err_cnt, bx_err_cnt); end
        set_frame(lb[2:0] ^ 3'b100, 1'b0); tick();
        checks++; if (locked !== 1'b1 || bx_err_cnt !== 16'd11) begin
            errors++; $display("FAIL run_cleared: locked %0b bx_err %0d want 1/11", locked, bx_err_cnt); end
        drive_good(1);
    endtask

    task automatic test_fields();
        logic [10:0] bf;
        set_frame(lb[2:0], 1'b0);
        rxdata[1] = rxdata[1] | mk_trk(9'd25, 4'd12, 9'h1a3, 8'h5c, 1'b1, 1'b0, 16'h1234, 2'd1, lb[10:0]);
        tick();
        checks++; if (trk_vld !== 3'b010) begin errors++; $display("FAIL fld_vld: got %b want 010", trk_vld); end
        checks++; if (trk_pt[1] !== 9'd25 || trk_qlt[1] !== 4'd12 || trk_eta[1] !== 9'h1a3 || trk_phi[1] !== 8'h5c) begin
            errors++; $display("FAIL fld_kin: pt %0d qlt %0d eta %0h phi %0h want 25/12/1a3/5c",
                               trk_pt[1], trk_qlt[1], trk_eta[1], trk_phi[1]); end
        checks++; if (trk_crg !== 3'b010 || trk_cvl !== 3'b000 || trk_id[1] !== 16'h1234 || trk_pt[0] !== 9'd0) begin
            errors++; $display("FAIL fld_misc: crg %b cvl %b id %0h pt0 %0d want 010/000/1234/0",
                               trk_crg, trk_cvl, trk_id[1], trk_pt[0]); end
        checks++; if (idx_err_cnt !== 16'd0) begin errors++; $display("FAIL idx_ok: got %0d want 0", idx_err_cnt); end

        set_frame(lb[2:0], 1'b0);
        rxdata[1] = rxdata[1] | mk_trk(9'd25, 4'd12, 9'h1a3, 8'h5c, 1'b1, 1'b0, 16'h1234, 2'd2, lb[10:0]);
        tick();
        checks++; if (idx_err_cnt !== 16'd1) begin errors++; $display("FAIL idx_wrong: got %0d want 1", idx_err_cnt); end

        set_frame(lb[2:0], 1'b0);
        rxdata[0] = rxdata[0] | mk_trk(9'd0, 4'd0, 9'd0, 8'd0, 1'b0, 1'b0, 16'hbeef, 2'd0, lb[10:0]);
        rxdata[1] = rxdata[1] | mk_trk(9'd0, 4'd5, 9'd3, 8'd4, 1'b0, 1'b0, 16'h0001, 2'd1, lb[10:0]);
        rxdata[2] = rxdata[2] | mk_trk(9'd7, 4'd0, 9'd0, 8'd0, 1'b0, 1'b1, 16'h00a0, 2'd2, lb[10:0]);
        tick();
        checks++; if (trk_vld !== 3'b110 || trk_id[0] !== 16'd0) begin
            errors++; $display("FAIL fld_partial_vld: vld %b id0 %0h want 110/0", trk_vld, trk_id[0]); end
        checks++; if (trk_qlt[1] !== 4'd5 || trk_pt[2] !== 9'd7 || trk_cvl !== 3'b100) begin
            errors++; $display("FAIL fld_partial: qlt1 %0d pt2 %0d cvl %b want 5/7/100", trk_qlt[1], trk_pt[2], trk_cvl); end
        checks++; if (idx_err_cnt !== 16'd1) begin errors++; $display("FAIL idx_partial: got %0d want 1", idx_err_cnt); end

        bf = lb[10:0] + 11'd1;
        set_frame(lb[2:0], 1'b0);
        for (int i = 0; i < 3; i++)
            rxdata[i] = rxdata[i] | mk_trk(9'd1, 4'd1, 9'd0, 8'd0, 1'b0, 1'b0, 16'd0, 2'(i), bf);
        tick();
        checks++; if (idx_err_cnt !== 16'd4 || trk_vld !== 3'b111) begin
            errors++; $display("FAIL idx_bxn_3slots: cnt %0d vld %b want 4/111", idx_err_cnt, trk_vld); end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        set_frame(lb[2:0], 1'b0);
        tick();
        checks++; if (bx_err_cnt !== 16'd0 || idx_err_cnt !== 16'd0 || bc0_err_cnt !== 16'd0 || locked !== 1'b0) begin
            errors++; $display("FAIL mid_reset: bx %0d idx %0d bc0 %0d locked %0b want 0/0/0/0",
                               bx_err_cnt, idx_err_cnt, bc0_err_cnt, locked); end
        rst_n = 1'b1;
    endtask

    task automatic test_bc0_err();
        set_frame(3'd0, 1'b1); tick();
        drive_good(100);
        set_frame(lb[2:0], 1'b1); tick();
        checks++; if (bc0_err_cnt !== 16'd1 || locked !== 1'b1) begin
            errors++; $display("FAIL bc0_early: cnt %0d locked %0b want 1/1", bc0_err_cnt, locked); end
        drive_good(3563);
        checks++; if (bc0_err_cnt !== 16'd1 || locked !== 1'b1) begin
            errors++; $display("FAIL bc0_pre_missing: cnt %0d locked %0b want 1/1", bc0_err_cnt, locked); end
        drive_good(1);
        checks++; if (bc0_err_cnt !== 16'd2 || locked !== 1'b0 || bx_err_cnt !== 16'd0) begin
            errors++; $display("FAIL bc0_missing: cnt %0d locked %0b bx_err %0d want 2/0/0",
                               bc0_err_cnt, locked, bx_err_cnt); end
    endtask

    task automatic test_rate();
        rst_n = 1'b0; rxdata = '0; tick(); rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            rxdata = '0; rxdata[0][0] = 1'b1; rxdata[2][0] = (k % 2 == 1);
            tick();
        end
        checks++; if (track_rate[0] !== 26'd0) begin errors++; $display("FAIL rate_early: got %0d want 0", track_rate[0]); end
        tick();
        checks++; if (track_rate[0] !== 26'd100 || track_rate[1] !== 26'd0 || track_rate[2] !== 26'd50) begin
            errors++; $display("FAIL rate_window: got %0d/%0d/%0d want 100/0/50",
                               track_rate[0], track_rate[1], track_rate[2]); end
        rxdata = '0; rxdata[0][0] = 1'b1;
        repeat (50) tick();
        rst_n = 1'b0; tick();
        checks++; if (track_rate !== '0) begin errors++; $display("FAIL rate_reset: got %0h want 0", track_rate); end
        rst_n = 1'b1;
        repeat (10) tick();
        rxdata = '0;
        repeat (91) tick();
        checks++; if (track_rate[0] !== 26'd10) begin errors++; $display("FAIL rate_after_reset: got %0d want 10", track_rate[0]); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_bx_err();
        test_fields();
        test_reset_mid();
        test_bc0_err();
        test_rate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
